// File: rtl/pwm_duty_capture.sv
`timescale 1ns/1ps
// pwm_duty_capture: measures high time and rising-to-rising period of one PWM
// line in clk cycles. Results are held with a valid/ack handshake, and a line
// that stays at one level for TIMEOUT cycles raises a stuck flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | disabled, counter cleared
// SYNC_WAIT | ignore the current level, wait for the first rising edge
// HIGH      | input high, counting high time (and period)
// LOW       | input low, counting the rest of the period
// STUCK     | no edge for TIMEOUT cycles, stuck flag held
module pwm_duty_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             overrun,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC_WAIT, S_HIGH, S_LOW, S_STUCK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d_q, rise, fall;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]       high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   stuck_high_q, stuck_high_d;
  logic                   stuck_low_q, stuck_low_d;
  logic                   complete;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + ONE;

  // Synchroniser chain for the asynchronous input plus one delay for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  // Next-state, counter and result handshake logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_tmp_d   = high_tmp_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    complete     = 1'b0;

    if (!en) begin
      // Results are kept so software can still read the last value.
      state_d      = S_IDLE;
      cnt_d        = '0;
      valid_d      = 1'b0;
      overrun_d    = 1'b0;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SYNC_WAIT;
          cnt_d   = '0;
        end
        S_SYNC_WAIT: begin
          if (rise) begin
            state_d = S_HIGH;
            cnt_d   = ONE;
          end else if (cnt_q == TMO) begin
            state_d      = S_STUCK;
            stuck_high_d = s;
            stuck_low_d  = ~s;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_HIGH: begin
          // The counter keeps running through the fall: it measures the period.
          cnt_d = cnt_inc;
          if (fall) begin
            high_tmp_d = cnt_q;
            state_d    = S_LOW;
          end else if (cnt_q == TMO) begin
            stuck_high_d = 1'b1;
            state_d      = S_STUCK;
          end
        end
        S_LOW: begin
          if (rise) begin
            complete = 1'b1;
            cnt_d    = ONE;
            state_d  = S_HIGH;
          end else if (cnt_q == TMO) begin
            stuck_low_d = 1'b1;
            state_d     = S_STUCK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STUCK: begin
          if (rise) begin
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            cnt_d        = ONE;
            state_d      = S_HIGH;
          end else if (fall) begin
            // A fall leaves only a partial period, so resynchronise.
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            cnt_d        = '0;
            state_d      = S_SYNC_WAIT;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (complete) begin
        if (!valid_q || meas_ack) begin
          high_cnt_d   = high_tmp_q;
          period_cnt_d = cnt_q;
          valid_d      = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (meas_ack && valid_q) begin
        valid_d = 1'b0;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      high_tmp_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_tmp_q   <= high_tmp_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = valid_q;
  assign overrun    = overrun_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
`timescale 1ns/1ps
// Directed bench for pwm_duty_capture: a PWM source whose high time, period
// and mode (normal / constant low / constant high) change only at a period
// wrap, with hand-computed expected measurements.
module tb_pwm_duty_capture;

  logic        clk = 1'b0;
  logic        rst, en, pwm_in, meas_ack;
  logic [15:0] high_cnt, period_cnt;
  logic        meas_valid, overrun, stuck_high, stuck_low;

  int n_vec = 0;
  int n_bad = 0;

  int gen_h = 64, gen_p = 256, gen_mode = 0;
  int cur_h = 64, cur_p = 256, cur_mode = 0, ph = 0;
  int rise_cnt = 0;
  int snap, h, p;

  pwm_duty_capture dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .meas_ack   (meas_ack),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;

  // PWM source: mode 0 normal, 1 constant low, 2 constant high.
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      pwm_in = (cur_mode == 2) || (cur_mode == 0 && ph < cur_h);
      ph++;
      if (ph >= cur_p) begin
        ph       = 0;
        cur_h    = gen_h;
        cur_p    = gen_p;
        cur_mode = gen_mode;
      end
    end
  end

  always @(posedge pwm_in) rise_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return meas_valid;
      1:       return overrun;
      2:       return stuck_high;
      default: return stuck_low;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int which, input logic level, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(which) === level) break;
    end
    chk(tag, 32'(sig(which)), 32'(level));
  endtask

  task automatic get_result(input string tag, input int budget, output int rh, output int rp);
    wait_until(tag, 0, 1'b1, budget);
    rh = int'(high_cnt);
    rp = int'(period_cnt);
    meas_ack = 1'b1;
    @(negedge clk);
    meas_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; meas_ack = 1'b0;
    #23;
    chk("rst_high_cnt",   32'(high_cnt),   0);
    chk("rst_period_cnt", 32'(period_cnt), 0);
    chk("rst_valid",      32'(meas_valid), 0);
    chk("rst_overrun",    32'(overrun),    0);
    chk("rst_stuck_high", 32'(stuck_high), 0);
    chk("rst_stuck_low",  32'(stuck_low),  0);
    @(negedge clk);
    rst = 1'b0;

    // 64/256: first result only after the second rise following enable.
    @(posedge pwm_in);
    repeat (10) @(negedge clk);
    en   = 1'b1;
    snap = rise_cnt;
    get_result("t1_valid", 700, h, p);
    chk("t1_rises", 32'(rise_cnt - snap), 2);
    chk("t1_high", 32'(h), 64);
    chk("t1_period", 32'(p), 256);
    for (int i = 0; i < 2; i++) begin
      get_result("t1_valid_n", 300, h, p);
      chk("t1_high_n", 32'(h), 64);
      chk("t1_period_n", 32'(p), 256);
    end

    // 128/256 then 192/256; the switch-over result is skipped.
    gen_h = 128;
    repeat (2) get_result("t2_skip", 300, h, p);
    get_result("t2_valid128", 300, h, p);
    chk("t2_high128", 32'(h), 128);
    chk("t2_period128", 32'(p), 256);
    gen_h = 192;
    repeat (2) get_result("t2_skip", 300, h, p);
    for (int i = 0; i < 2; i++) begin
      get_result("t2_valid192", 300, h, p);
      chk("t2_high192", 32'(h), 192);
      chk("t2_period192", 32'(p), 256);
    end

    // Overrun with ack held low, then ack coincident with a completion.
    gen_h = 64;
    repeat (2) get_result("t3_skip", 300, h, p);
    wait_until("t3_valid", 0, 1'b1, 300);
    chk("t3_high_first", 32'(high_cnt), 64);
    gen_h = 128;
    wait_until("t3_overrun", 1, 1'b1, 300);
    chk("t3_high_held", 32'(high_cnt), 64);
    chk("t3_period_held", 32'(period_cnt), 256);
    chk("t3_valid_held", 32'(meas_valid), 1);
    @(posedge pwm_in);
    repeat (2) @(negedge clk);
    meas_ack = 1'b1;
    @(negedge clk);
    meas_ack = 1'b0;
    chk("t3_coinc_valid", 32'(meas_valid), 1);
    chk("t3_coinc_high", 32'(high_cnt), 128);
    chk("t3_coinc_period", 32'(period_cnt), 256);
    chk("t3_coinc_overrun", 32'(overrun), 1);
    meas_ack = 1'b1;
    @(negedge clk);
    meas_ack = 1'b0;
    chk("t3_acked", 32'(meas_valid), 0);

    // Constant low: stuck_low exactly on the 1024th count.
    en       = 1'b0;
    gen_h    = 64;
    gen_mode = 1;
    repeat (600) @(negedge clk);
    en = 1'b1;
    repeat (1025) @(negedge clk);
    chk("t4_stuck_low_early", 32'(stuck_low), 0);
    @(negedge clk);
    chk("t4_stuck_low", 32'(stuck_low), 1);
    chk("t4_valid", 32'(meas_valid), 0);
    gen_mode = 0;
    wait_until("t4_stuck_low_clr", 3, 1'b0, 600);
    get_result("t4_valid_after", 600, h, p);
    chk("t4_high", 32'(h), 64);
    chk("t4_period", 32'(p), 256);

    // Line held high mid-HIGH, then a fall resynchronises.
    gen_mode = 2;
    get_result("t5_last", 600, h, p);
    chk("t5_last_high", 32'(h), 64);
    wait_until("t5_stuck_high", 2, 1'b1, 1500);
    chk("t5_valid", 32'(meas_valid), 0);
    gen_mode = 0;
    wait_until("t5_stuck_high_clr", 2, 1'b0, 600);
    chk("t5_valid_clr", 32'(meas_valid), 0);
    repeat (250) @(negedge clk);
    chk("t5_no_early_result", 32'(meas_valid), 0);
    get_result("t5_valid_after", 400, h, p);
    chk("t5_high", 32'(h), 64);
    chk("t5_period", 32'(p), 256);

    // Drop en mid-HIGH with a pending result and overrun.
    wait_until("t6_overrun", 1, 1'b1, 700);
    @(posedge pwm_in);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(meas_valid), 0);
    chk("t6_overrun", 32'(overrun), 0);
    chk("t6_stuck_high", 32'(stuck_high), 0);
    chk("t6_stuck_low", 32'(stuck_low), 0);
    chk("t6_high_kept", 32'(high_cnt), 64);
    chk("t6_period_kept", 32'(period_cnt), 256);
    en   = 1'b1;
    snap = rise_cnt;
    get_result("t6_valid_after", 700, h, p);
    chk("t6_rises", 32'(rise_cnt - snap), 2);
    chk("t6_high", 32'(h), 64);
    chk("t6_period", 32'(p), 256);

    // Asynchronous reset mid-LOW.
    wait_until("t7_valid", 0, 1'b1, 300);
    @(posedge pwm_in);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_valid", 32'(meas_valid), 0);
    chk("t7_overrun", 32'(overrun), 0);
    chk("t7_high", 32'(high_cnt), 0);
    chk("t7_period", 32'(period_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
